// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm -- control FSM of the UART receiver.
//
// Walks a frame (start, DATA_WIDTH data bits LSB first, optional parity, stop) by counting
// oversampling edges inside each bit. It pulses the enables for the sampler, deserializer and
// start/parity/stop checkers, reads their error flags on the last edge of each bit, and reports
// each frame as either accepted (data_valid) or dropped (frame_err).
//
// Parameters: DATA_WIDTH data bits per frame; PRESC_W width of Prescale and edge_cnt.
// Ports:
//   clk, rst (sync, active-high), EN (low acts like rst)
//   RX_IN serial line (idle high), Prescale oversampling ratio (8/16/32), PAR_EN parity enable
//   Start_glitch / Par_err / Stop_err  checker flags, valid one cycle after their check pulse
//   edge_cnt, bit_cnt                  position inside the frame (0 in IDLE)
//   data_samp_en                       high in every non-IDLE state
//   deser_en, Start_check_en, Par_check_en, Stop_check_en  one-cycle pulses at edge H+2
//   data_valid, frame_err              one-cycle frame outcome pulses
// Optional build (macro UART_RX_BREAK_DET_EN): adds input sampled_bit and output break_det.
// A stop failure on an all-zero frame pulses break_det with frame_err, and the FSM then stays
// in IDLE until RX_IN has been high for P consecutive cycles.
module uart_rx_fsm #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               EN,
  input  logic               RX_IN,
  input  logic [PRESC_W-1:0] Prescale,
  input  logic               PAR_EN,
  input  logic               Start_glitch,
  input  logic               Par_err,
  input  logic               Stop_err,
`ifdef UART_RX_BREAK_DET_EN
  input  logic               sampled_bit,
  output logic               break_det,
`endif
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [3:0]         bit_cnt,
  output logic               data_samp_en,
  output logic               deser_en,
  output logic               Start_check_en,
  output logic               Par_check_en,
  output logic               Stop_check_en,
  output logic               data_valid,
  output logic               frame_err
);

  localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t             state;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] half;
  logic               last_edge;
  logic               mid_edge;

`ifdef UART_RX_BREAK_DET_EN
  logic               ones_seen;
  logic               hold;
  logic [PRESC_W-1:0] hold_cnt;
`endif

  assign half      = presc >> 1;
  assign last_edge = (edge_cnt == presc - 1'b1);
  // Pulses are registered, so they are launched one edge early to be high while edge_cnt == H+2,
  // the first edge at which the sampler's 3-edge majority vote (H-1..H+1) is settled.
  assign mid_edge  = (edge_cnt == half + 1'b1);

  always_ff @(posedge clk) begin
    if (rst || !EN) begin
      state          <= IDLE;
      edge_cnt       <= '0;
      bit_cnt        <= '0;
      data_samp_en   <= 1'b0;
      deser_en       <= 1'b0;
      Start_check_en <= 1'b0;
      Par_check_en   <= 1'b0;
      Stop_check_en  <= 1'b0;
      data_valid     <= 1'b0;
      frame_err      <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      break_det      <= 1'b0;
      ones_seen      <= 1'b0;
      hold           <= 1'b0;
      hold_cnt       <= '0;
`endif
    end else begin
      deser_en       <= 1'b0;
      Start_check_en <= 1'b0;
      Par_check_en   <= 1'b0;
      Stop_check_en  <= 1'b0;
      data_valid     <= 1'b0;
      frame_err      <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      break_det      <= 1'b0;
`endif

      if (state != IDLE) begin
        if (last_edge) begin
          edge_cnt <= '0;
          bit_cnt  <= bit_cnt + 4'd1;
        end else begin
          edge_cnt <= edge_cnt + 1'b1;
        end
      end

      case (state)
        IDLE: begin
`ifdef UART_RX_BREAK_DET_EN
          // After a break the line must return to idle for a full bit time before re-arming.
          if (hold) begin
            if (!RX_IN)
              hold_cnt <= '0;
            else if (hold_cnt == presc - 1'b1)
              hold <= 1'b0;
            else
              hold_cnt <= hold_cnt + 1'b1;
          end else
`endif
          if (!RX_IN) begin
            state        <= START;
            presc        <= Prescale;
            data_samp_en <= 1'b1;
          end
        end

        START: begin
          Start_check_en <= mid_edge;
`ifdef UART_RX_BREAK_DET_EN
          ones_seen      <= 1'b0;
`endif
          if (last_edge) begin
            if (Start_glitch) begin
              state        <= IDLE;
              bit_cnt      <= '0;
              data_samp_en <= 1'b0;
              frame_err    <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end

        DATA: begin
          deser_en <= mid_edge;
`ifdef UART_RX_BREAK_DET_EN
          if (deser_en) ones_seen <= ones_seen | sampled_bit;
`endif
          if (last_edge && bit_cnt == LAST_DATA)
            state <= PAR_EN ? PARITY : STOP;
        end

        PARITY: begin
          Par_check_en <= mid_edge;
          if (last_edge) begin
            if (Par_err) begin
              state        <= IDLE;
              bit_cnt      <= '0;
              data_samp_en <= 1'b0;
              frame_err    <= 1'b1;
            end else begin
              state <= STOP;
            end
          end
        end

        STOP: begin
          Stop_check_en <= mid_edge;
          if (last_edge) begin
            bit_cnt <= '0;
            if (Stop_err) begin
              state        <= IDLE;
              data_samp_en <= 1'b0;
              frame_err    <= 1'b1;
`ifdef UART_RX_BREAK_DET_EN
              if (!ones_seen) begin
                break_det <= 1'b1;
                hold      <= 1'b1;
                hold_cnt  <= '0;
              end
`endif
            end else begin
              data_valid <= 1'b1;
              // A low line on the last stop edge is the next start bit: skip IDLE.
              if (RX_IN) begin
                state        <= IDLE;
                data_samp_en <= 1'b0;
              end else begin
                state <= START;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Testbench for uart_rx_fsm: directed frames plus randomized frames, each cycle compared against
// an arithmetic model of where the FSM must be inside the frame (bit = n / P, edge = n % P).
module tb_uart_rx_fsm;
  localparam int DW = 8;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst, EN, RX_IN, PAR_EN, Start_glitch, Par_err, Stop_err;
  logic [PW-1:0] Prescale;
  logic [PW-1:0] edge_cnt;
  logic [3:0]    bit_cnt;
  logic          data_samp_en, deser_en, Start_check_en, Par_check_en, Stop_check_en;
  logic          data_valid, frame_err;
`ifdef UART_RX_BREAK_DET_EN
  logic          sampled_bit, break_det;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int dv_last = 0;
  int dv_prev = 0;

  uart_rx_fsm #(.DATA_WIDTH(DW), .PRESC_W(PW)) dut (
    .clk(clk), .rst(rst), .EN(EN), .RX_IN(RX_IN), .Prescale(Prescale), .PAR_EN(PAR_EN),
    .Start_glitch(Start_glitch), .Par_err(Par_err), .Stop_err(Stop_err),
`ifdef UART_RX_BREAK_DET_EN
    .sampled_bit(sampled_bit), .break_det(break_det),
`endif
    .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .data_samp_en(data_samp_en), .deser_en(deser_en),
    .Start_check_en(Start_check_en), .Par_check_en(Par_check_en), .Stop_check_en(Stop_check_en),
    .data_valid(data_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (data_valid) begin
      dv_prev = dv_last;
      dv_last = cyc;
    end
  endtask

  // Layout: {pad, edge_cnt, bit_cnt, samp_en, deser, start_chk, par_chk, stop_chk, data_valid, frame_err}
  function automatic logic [31:0] obs_vec();
    return {15'b0, edge_cnt, bit_cnt, data_samp_en, deser_en, Start_check_en, Par_check_en,
            Stop_check_en, data_valid, frame_err};
  endfunction

  // Expected outputs in cycle n of a frame (n = 0 is the first START cycle).
  function automatic logic [31:0] exp_vec(input int n, input int p, input bit par);
    int b, e, h;
    bit m;
    b = n / p;
    e = n % p;
    h = p / 2;
    m = (e == h + 2);
    return {15'b0, 6'(e), 4'(b), 1'b1, m && b >= 1 && b <= DW, m && b == 0,
            m && par && b == DW + 1, m && b == DW + 1 + int'(par), 2'b00};
  endfunction

  task automatic idle_cycles(input int n, input bit rx);
    RX_IN = rx;
    for (int i = 0; i < n; i++) begin
      step();
      chk("idle", obs_vec(), 32'h0);
    end
  endtask

  // err: 0 none, 1 start glitch, 2 parity error, 3 stop error.
  // b2b_out: drive the next start bit on the last stop edge; started: this frame was entered that way.
  task automatic run_frame(input int p, input bit par, input logic [7:0] data, input int err,
                           input bit b2b_out, input bit started, input int abort_n, input bit abort_en);
    int h, endb, len, b, e, stop_b;
    bit good;
    logic [31:0] ev;
    h = p / 2;
    stop_b = DW + 1 + int'(par);
    if (err == 1) endb = 0;
    else if (err == 2 && par) endb = DW + 1;
    else endb = stop_b;
    len = (endb + 1) * p;
    good = (endb == stop_b) && (err != 3);
    PAR_EN = par;
    if (!started) begin
      Prescale = PW'(p);
      RX_IN = 1'b0;
    end
    for (int n = 0; n < len; n++) begin
      step();
      ev = exp_vec(n, p, par);
      if (n == 0 && started) ev = ev | 32'h2;
      chk("frame", obs_vec(), ev);
      if (n == abort_n) begin
        if (abort_en) EN = 1'b0;
        else rst = 1'b1;
        RX_IN = 1'b1;
        step();
        if (abort_en) chk("en_clear", obs_vec(), 32'h0);
        else chk("rst_clear", obs_vec(), 32'h0);
        EN = 1'b1;
        rst = 1'b0;
        Start_glitch = 1'b0;
        Par_err = 1'b0;
        Stop_err = 1'b0;
        return;
      end
      b = n / p;
      e = n % p;
      if (b == 0) RX_IN = (err == 1 && n >= 2);
      else if (b <= DW) RX_IN = data[b-1];
      else if (b == DW + 1 && par) RX_IN = ^data;
      else RX_IN = !(b2b_out && n == len - 1);
`ifdef UART_RX_BREAK_DET_EN
      sampled_bit = (b >= 1 && b <= DW) ? data[b-1] : 1'b1;
`endif
      Start_glitch = (err == 1 && b == 0 && e >= h + 3);
      Par_err      = (err == 2 && par && b == DW + 1 && e >= h + 3);
      Stop_err     = (err == 3 && b == stop_b && e >= h + 3);
      // Prescale is only captured at frame start; changing it now must not matter.
      if (n == 1) Prescale = PW'(p == 16 ? 32 : 16);
    end
    if (!b2b_out) begin
      step();
      if (good) chk("dv_end", obs_vec(), 32'h2);
      else chk("err_end", obs_vec(), 32'h1);
`ifdef UART_RX_BREAK_DET_EN
      chk("break_det", 32'(break_det), 32'(err == 3 && data == 8'h00));
`endif
      Start_glitch = 1'b0;
      Par_err = 1'b0;
      Stop_err = 1'b0;
      RX_IN = 1'b1;
      step();
      chk("pulse_width", obs_vec(), 32'h0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int p, err;
    bit par;
    logic [7:0] d;
    rst = 1'b1;
    EN = 1'b1;
    RX_IN = 1'b1;
    PAR_EN = 1'b0;
    Prescale = 6'd8;
    Start_glitch = 1'b0;
    Par_err = 1'b0;
    Stop_err = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    sampled_bit = 1'b0;
`endif
    repeat (3) step();
    chk("reset_state", obs_vec(), 32'h0);
    rst = 1'b0;
    idle_cycles(3, 1'b1);

    // Good frame, P=8, no parity.
    run_frame(8, 1'b0, 8'hA5, 0, 1'b0, 1'b0, -1, 1'b0);
    idle_cycles(2, 1'b1);
    // Parity error, P=16.
    run_frame(16, 1'b1, 8'h3C, 2, 1'b0, 1'b0, -1, 1'b0);
    idle_cycles(2, 1'b1);
    // Stop error then a good frame.
    run_frame(8, 1'b0, 8'h5A, 3, 1'b0, 1'b0, -1, 1'b0);
    idle_cycles(2, 1'b1);
    run_frame(8, 1'b0, 8'hC3, 0, 1'b0, 1'b0, -1, 1'b0);
    idle_cycles(2, 1'b1);
    // Back-to-back frames at P=32.
    run_frame(32, 1'b0, 8'h81, 0, 1'b1, 1'b0, -1, 1'b0);
    run_frame(32, 1'b0, 8'h7E, 0, 1'b0, 1'b1, -1, 1'b0);
    chk("b2b_gap", 32'(dv_last - dv_prev), 32'd320);
    idle_cycles(2, 1'b1);
    // Start glitch.
    run_frame(8, 1'b0, 8'hFF, 1, 1'b0, 1'b0, -1, 1'b0);
    idle_cycles(2, 1'b1);
    // rst and then EN low in DATA bit 4.
    run_frame(8, 1'b0, 8'h96, 0, 1'b0, 1'b0, 4 * 8 + 3, 1'b0);
    idle_cycles(3, 1'b1);
    run_frame(8, 1'b1, 8'h96, 0, 1'b0, 1'b0, 4 * 8 + 3, 1'b1);
    idle_cycles(3, 1'b1);
    run_frame(16, 1'b1, 8'h11, 0, 1'b0, 1'b0, -1, 1'b0);
    idle_cycles(2, 1'b1);

    for (int k = 0; k < 14; k++) begin
      case ($urandom_range(0, 2))
        0: p = 8;
        1: p = 16;
        default: p = 32;
      endcase
      par = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      err = $urandom_range(0, 3);
      if (err == 3 && d == 8'h00) d = 8'h01;
      run_frame(p, par, d, err, 1'b0, 1'b0, -1, 1'b0);
      idle_cycles($urandom_range(1, 4), 1'b1);
    end

`ifdef UART_RX_BREAK_DET_EN
    run_frame(8, 1'b0, 8'h00, 3, 1'b0, 1'b0, -1, 1'b0);
    idle_cycles(4, 1'b0);
    idle_cycles(7, 1'b1);
    idle_cycles(3, 1'b0);
    idle_cycles(8, 1'b1);
    run_frame(8, 1'b0, 8'h42, 0, 1'b0, 1'b0, -1, 1'b0);
    idle_cycles(2, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
